lut_neuron_loader: RTL and testbench
====================================

Name: lut_neuron_loader

Overview:
- Runtime-writable counterpart to the fixed-ROM LUT neurons.
- Accepts a neuron truth table as a valid/ready stream of packed words and writes it into an internal 2^IN_BITS x OUT_BITS distributed table.
- Once loaded, serves registered lookups with the same M0 -> M1 semantics as a generated layer neuron.
- Sits between the config/DMA path and a layer slot, so tables can be swapped without resynthesis.

Parameters:
IN_BITS, 8, neuron input width; table depth = 2^IN_BITS
OUT_BITS, 2, neuron output width; table entry width
CFG_W, 8, config word width; must be a multiple of OUT_BITS; entries per word EPW = CFG_W/OUT_BITS (4)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle pulse: begin (re)loading the table from address 0
cfg_valid  in  1  cfg_data valid
cfg_data  in  CFG_W  packed entries; entry k at bits [k*OUT_BITS +: OUT_BITS], addresses ascending from LSB
cfg_ready  out  1  load engine accepts a word this cycle
cfg_done  out  1  level: a complete table is loaded and lookups are live
cfg_err  out  1  sticky: cfg_start received mid-load; cleared only by reset
in_valid  in  1  lookup request
M0  in  IN_BITS  lookup address (neuron input vector)
out_valid  out  1  M1 valid
M1  out  OUT_BITS  looked-up neuron output

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE; cfg_ready, cfg_done, cfg_err, out_valid and M1 all 0; word counter 0.
  - Table contents are not reset.
- States: IDLE, LOAD, READY.
- IDLE:
  - cfg_ready=0.
  - cfg_start -> LOAD; counter=0.
- LOAD:
  - cfg_ready=1 every cycle; a word is accepted on cfg_valid&cfg_ready.
  - On accept: entry k (k=0..EPW-1) is written to address counter*EPW+k; counter++.
  - The write is visible to lookups from the cycle after the accept.
  - Accepting word number 2^IN_BITS/EPW-1 (63 by default) -> READY; cfg_done=1 registered on the next edge; cfg_ready=0 on the next cycle.
  - cfg_start in LOAD: counter=0, stay in LOAD, cfg_err<=1. A word accepted in the same cycle as cfg_start is discarded.
- READY:
  - cfg_ready=0; cfg_data ignored.
  - cfg_start -> LOAD; cfg_done<=0 on the same edge.
- Lookup path:
  - 1-cycle latency: if in_valid && state==READY at edge t, then at t+1 out_valid=1 and M1=table[M0 sampled at t].
  - Otherwise out_valid=0 and M1=0 at t+1.
  - Lookups issued while in IDLE or LOAD are dropped, not queued.
  - Back-to-back lookups sustain 1 per cycle. No backpressure on the output.
- Simultaneous cfg_start and in_valid in READY: the lookup is dropped (state leaves READY on that edge), out_valid=0 next cycle.
- Counter width is log2(2^IN_BITS/EPW). No wrap is possible, because LOAD exits on the last word.
- Reset mid-LOAD: returns to IDLE; the partial table is retained but cfg_done=0, so nothing can read it until a full reload.

Test Plan:
- Reset then in_valid=1, M0=8'h5A for 4 cycles -> out_valid=0, M1=0 throughout; cfg_ready=0.
- cfg_start, then 64 words all 8'h00 with cfg_valid held high:
  - cfg_ready high 64 cycles; cfg_done rises 1 cycle after the 64th accept.
  - Any lookup returns M1=2'b00, out_valid=1 one cycle after in_valid (matches the all-zero generated neuron).
- Load word w = {w[1:0],w[1:0],w[1:0],w[1:0]} for w=0..63, with cfg_valid toggling every other cycle:
  - exactly 64 accepts.
  - Sweep M0=0..255 back-to-back -> M1 = (M0>>2)&3 every cycle, out_valid continuous.
- Mid-load restart: after 10 words, pulse cfg_start with cfg_valid=1 -> that word is dropped, cfg_err=1 (sticky), counter restarts. Then 64 words of 8'hFF -> cfg_done=1 and all lookups return 2'b11.
- In READY, pulse cfg_start with in_valid=1 the same cycle -> out_valid=0 next cycle, cfg_done falls. Assert rst_n=0 after 5 more words -> all outputs 0 immediately (asynchronously).

Source files
------------

// File: rtl/lut_neuron_loader.sv
// lut_neuron_loader
//   Runtime-loadable LUT neuron. A truth table arrives as a valid/ready
//   stream of packed config words and is written into an internal
//   2^IN_BITS x OUT_BITS distributed table. Once a complete table has been
//   loaded, the block serves registered lookups (M0 -> M1, 1-cycle latency)
//   with the same behaviour as a generated fixed-ROM layer neuron.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   cfg_start       pulse: (re)start loading from address 0
//   cfg_valid/data  config word stream; entry k at bits [k*OUT_BITS +: OUT_BITS]
//   cfg_ready       load engine accepts a word this cycle
//   cfg_done        level: full table loaded, lookups live
//   cfg_err         sticky: cfg_start seen mid-load (cleared by reset only)
//   in_valid, M0    lookup request and address
//   out_valid, M1   registered lookup result
`timescale 1ns/1ps

module lut_neuron_loader #(
    parameter int unsigned IN_BITS  = 8,
    parameter int unsigned OUT_BITS = 2,
    parameter int unsigned CFG_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    input  logic [CFG_W-1:0]    cfg_data,
    output logic                cfg_ready,
    output logic                cfg_done,
    output logic                cfg_err,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  M0,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] M1
);

    localparam int unsigned EPW    = CFG_W / OUT_BITS;
    localparam int unsigned DEPTH  = 1 << IN_BITS;
    localparam int unsigned NWORDS = DEPTH / EPW;
    localparam int unsigned CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                cfg_ready_q;
    logic                cfg_done_q;
    logic                cfg_err_q;
    logic                out_valid_q;
    logic [OUT_BITS-1:0] m1_q;

    // Table contents are intentionally not reset.
    logic [OUT_BITS-1:0] table_q [DEPTH];

    logic               word_accept;
    logic               last_word;
    logic               lookup;
    logic [IN_BITS-1:0] base_addr;

    // A word arriving together with cfg_start is discarded.
    assign word_accept = (state_q == LOAD) && cfg_valid && !cfg_start;
    assign last_word   = (cnt_q == CNT_W'(NWORDS - 1));
    // A lookup colliding with cfg_start in READY is dropped: state leaves READY.
    assign lookup      = in_valid && (state_q == READY) && !cfg_start;
    assign base_addr   = IN_BITS'(cnt_q) * IN_BITS'(EPW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cfg_ready_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            m1_q        <= '0;
        end else begin
            out_valid_q <= lookup;
            m1_q        <= lookup ? table_q[M0] : '0;

            case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        state_q     <= LOAD;
                        cnt_q       <= '0;
                        cfg_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        cnt_q     <= '0;
                        cfg_err_q <= 1'b1;
                    end else if (cfg_valid) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_word) begin
                            state_q     <= READY;
                            cfg_ready_q <= 1'b0;
                            cfg_done_q  <= 1'b1;
                        end
                    end
                end
                READY: begin
                    if (cfg_start) begin
                        state_q     <= LOAD;
                        cnt_q       <= '0;
                        cfg_ready_q <= 1'b1;
                        cfg_done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cfg_ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (word_accept) begin
            for (int unsigned k = 0; k < EPW; k++) begin
                table_q[base_addr + IN_BITS'(k)] <= cfg_data[k*OUT_BITS +: OUT_BITS];
            end
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_err   = cfg_err_q;
    assign out_valid = out_valid_q;
    assign M1        = m1_q;

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Self-checking bench for lut_neuron_loader (default parameters).
// Reference model: a plain array holding the table as the accepted word
// stream describes it, plus load/done/err flags derived from the stream.
`timescale 1ns/1ps

module tb_lut_neuron_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_ready;
    logic       cfg_done;
    logic       cfg_err;
    logic       in_valid = 1'b0;
    logic [7:0] M0 = 8'h00;
    logic       out_valid;
    logic [1:0] M1;

    lut_neuron_loader #(.IN_BITS(8), .OUT_BITS(2), .CFG_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .M0        (M0),
        .out_valid (out_valid),
        .M1        (M1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model
    bit          m_loading = 0;
    bit          m_done = 0;
    bit          m_err = 0;
    int unsigned n_loaded = 0;
    logic [1:0]  tbl [256];
    bit          last_acc;
    logic [5:0]  exp_vec;   // {cfg_ready, cfg_done, cfg_err, out_valid, M1}

    logic [5:0] obs;
    assign obs = {cfg_ready, cfg_done, cfg_err, out_valid, M1};

    // Advance one clock: evaluate the model on the inputs present before the
    // edge, then leave the expected post-edge outputs in exp_vec.
    task automatic step();
        bit         ov;
        logic [1:0] m1;
        ov = in_valid && m_done && !cfg_start;
        m1 = ov ? tbl[M0] : 2'b00;
        last_acc = 0;
        if (cfg_start) begin
            if (m_loading) m_err = 1;
            m_loading = 1;
            m_done    = 0;
            n_loaded  = 0;
        end else if (m_loading && cfg_valid) begin
            for (int k = 0; k < 4; k++) tbl[n_loaded*4 + k] = cfg_data[2*k +: 2];
            n_loaded++;
            last_acc = 1;
            if (n_loaded == 64) begin
                m_loading = 0;
                m_done    = 1;
            end
        end
        @(posedge clk);
        #1;
        exp_vec = {m_loading, m_done, m_err, ov, m1};
    endtask

    task automatic model_reset();
        m_loading = 0;
        m_done    = 0;
        m_err     = 0;
        n_loaded  = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== 6'b0) begin
            failures++;
            $display("FAIL reset_state: got rdy/done/err/ov/M1=%b want %b", obs, 6'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        M0 = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs !== 6'b0 || obs !== exp_vec) begin
                failures++;
                $display("FAIL idle_lookup cyc %0d: got %b want %b", i, obs, exp_vec);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_zero_load();
        int n_ready;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        checks++;
        if (obs !== exp_vec) begin
            failures++;
            $display("FAIL zero_start: got %b want %b", obs, exp_vec);
        end
        n_ready = (cfg_ready === 1'b1) ? 1 : 0;
        for (int w = 0; w < 64; w++) begin
            cfg_valid = 1'b1;
            cfg_data  = 8'h00;
            in_valid  = 1'($urandom_range(0, 1));
            M0        = 8'($urandom);
            step();
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL zero_load word %0d: got %b want %b", w, obs, exp_vec);
            end
            if (cfg_ready === 1'b1) n_ready++;
        end
        cfg_valid = 1'b0;
        checks++;
        if (n_ready != 64) begin
            failures++;
            $display("FAIL zero_ready_cycles: got %0d want %0d", n_ready, 64);
        end
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            M0 = 8'($urandom);
            step();
            checks++;
            if (obs !== exp_vec || {out_valid, M1} !== 3'b100) begin
                failures++;
                $display("FAIL zero_lookup M0=%0d: got %b want %b", M0, obs, exp_vec);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_pattern_load();
        int cyc = 0;
        int dut_acc = 0;
        int acc = 0;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        checks++;
        if (obs !== exp_vec) begin
            failures++;
            $display("FAIL pattern_start: got %b want %b", obs, exp_vec);
        end
        while (acc < 64 && cyc < 400) begin
            cfg_valid = (cyc % 2 == 0);
            cfg_data  = {4{acc[1:0]}};
            if (cfg_valid === 1'b1 && cfg_ready === 1'b1) dut_acc++;
            step();
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL pattern_load cyc %0d: got %b want %b", cyc, obs, exp_vec);
            end
            if (last_acc) acc++;
            cyc++;
        end
        cfg_valid = 1'b0;
        checks++;
        if (dut_acc != 64 || cfg_done !== 1'b1) begin
            failures++;
            $display("FAIL pattern_accepts: got %0d done=%b want 64 done=1", dut_acc, cfg_done);
        end
        in_valid = 1'b1;
        for (int a = 0; a < 256; a++) begin
            M0 = 8'(a);
            step();
            checks++;
            if (obs !== exp_vec || out_valid !== 1'b1 || M1 !== 2'((a >> 2) & 3)) begin
                failures++;
                $display("FAIL pattern_sweep M0=%0d: got ov=%b M1=%0d want ov=1 M1=%0d",
                         a, out_valid, M1, (a >> 2) & 3);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_restart();
        int acc = 0;
        int cyc = 0;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int w = 0; w < 10; w++) begin
            cfg_valid = 1'b1;
            cfg_data  = 8'($urandom);
            step();
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL restart_pre word %0d: got %b want %b", w, obs, exp_vec);
            end
        end
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'($urandom);
        step();
        cfg_start = 1'b0;
        checks++;
        if (obs !== exp_vec || cfg_err !== 1'b1) begin
            failures++;
            $display("FAIL restart_err: got %b want %b", obs, exp_vec);
        end
        while (acc < 64 && cyc < 1000) begin
            cfg_valid = 1'($urandom_range(0, 3) != 0);
            cfg_data  = 8'hFF;
            in_valid  = 1'($urandom_range(0, 1));
            M0        = 8'($urandom);
            step();
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL restart_load cyc %0d: got %b want %b", cyc, obs, exp_vec);
            end
            if (last_acc) acc++;
            cyc++;
        end
        cfg_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            M0 = 8'($urandom);
            step();
            checks++;
            if (obs !== exp_vec || {cfg_done, cfg_err, out_valid, M1} !== 5'b11111) begin
                failures++;
                $display("FAIL restart_lookup M0=%0d: got %b want %b", M0, obs, exp_vec);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_ready_restart_reset();
        cfg_start = 1'b1;
        in_valid  = 1'b1;
        M0        = 8'($urandom);
        step();
        cfg_start = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (obs !== exp_vec || out_valid !== 1'b0 || cfg_done !== 1'b0) begin
            failures++;
            $display("FAIL ready_restart: got %b want %b", obs, exp_vec);
        end
        for (int w = 0; w < 5; w++) begin
            cfg_valid = 1'b1;
            cfg_data  = 8'($urandom);
            step();
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL partial_load word %0d: got %b want %b", w, obs, exp_vec);
            end
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== 6'b0) begin
            failures++;
            $display("FAIL async_reset: got %b want %b", obs, 6'b0);
        end
        cfg_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            M0 = 8'($urandom);
            step();
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL post_reset_lookup cyc %0d: got %b want %b", i, obs, exp_vec);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random_table();
        int acc = 0;
        int cyc = 0;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        while (acc < 64 && cyc < 1000) begin
            cfg_valid = 1'($urandom_range(0, 9) < 6);
            cfg_data  = 8'($urandom);
            in_valid  = 1'($urandom_range(0, 1));
            M0        = 8'($urandom);
            step();
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL random_load cyc %0d: got %b want %b", cyc, obs, exp_vec);
            end
            if (last_acc) acc++;
            cyc++;
        end
        cfg_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            M0 = 8'($urandom);
            step();
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL random_lookup %0d: got %b want %b", i, obs, exp_vec);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_load();
        test_pattern_load();
        test_restart();
        test_ready_restart_reset();
        test_random_table();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
